// File: rtl/cache_set_ctrl_pkg.sv
// Shared types for the set-associative cache controller: command codes, MESI
// states, FSM states and a default-width way entry record.
package cache_set_ctrl_pkg;

  typedef enum logic [3:0] {
    CMD_READ  = 4'd0,
    CMD_WRITE = 4'd1,
    CMD_FETCH = 4'd2,
    CMD_INVAL = 4'd3,
    CMD_CLEAR = 4'd8,
    CMD_NOP   = 4'd9
  } n_t;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_FILL,
    ST_UPDATE,
    ST_CLEAR
  } state_t;

  localparam int DEFAULT_TAG_W = 22;
  localparam int DEFAULT_AGE_W = 3;

  typedef struct packed {
    logic [DEFAULT_TAG_W-1:0] tag;
    mesi_t                    mesi;
    logic [DEFAULT_AGE_W-1:0] age;
  } way_entry_t;

  // Commands that allocate on miss and move the LRU order.
  function automatic logic isAccessCmd(input logic [3:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE) || (cmd == CMD_FETCH);
  endfunction

endpackage

// File: rtl/cache_set_ctrl_lru_age_update.sv
// Combinational LRU age update for one set: the accessed way becomes youngest,
// ways younger than its old age grow one step older, the rest hold.
module lru_age_update
  #(parameter int WAYS = 8)
  (
    input  logic [WAYS-1:0][$clog2(WAYS)-1:0] i_ages,
    input  logic [$clog2(WAYS)-1:0]           i_way,
    output logic [WAYS-1:0][$clog2(WAYS)-1:0] o_ages
  );

  localparam int WAY_W = $clog2(WAYS);

  logic [WAY_W-1:0] w_oldAge;

  assign w_oldAge = i_ages[i_way];

  always_comb begin
    o_ages = i_ages;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == i_way)
        o_ages[w] = '0;
      else if (i_ages[w] < w_oldAge)
        o_ages[w] = i_ages[w] + 1'b1;
    end
  end

endmodule

// File: rtl/cache_set_ctrl.sv
// Set-associative cache controller: tag/MESI/LRU state, lookup, writeback, fill.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_set_ctrl
  import cache_set_ctrl_pkg::*;
  #(
    parameter int WAYS     = 8,
    parameter int SETS     = 16,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6
  )
  (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_cmd,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [$clog2(WAYS)-1:0] resp_way,
    output logic [1:0]              resp_mesi,
    output logic                    mem_req_valid,
    output logic                    mem_req_wb,
    output logic [ADDR_W-1:0]       mem_req_addr,
    input  logic                    mem_ack,
    input  logic                    mem_shared
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
`endif
  );

  localparam int WAY_W  = $clog2(WAYS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int TAG_W  = LINE_W - IDX_W;

  logic [TAG_W-1:0]           r_tag  [SETS][WAYS];
  mesi_t                      r_mesi [SETS][WAYS];
  logic [WAYS-1:0][WAY_W-1:0] r_age  [SETS];

  state_t           r_state;
  logic [3:0]       r_cmd;
  logic [LINE_W-1:0] r_line;
  logic [WAY_W-1:0] r_way;
  logic             r_hit;
  mesi_t            r_newMesi;
  logic [IDX_W-1:0] r_clrSet;

  logic [IDX_W-1:0]           w_set;
  logic [TAG_W-1:0]           w_reqTag;
  logic                       w_hit;
  logic [WAY_W-1:0]           w_hitWay;
  mesi_t                      w_hitMesi;
  logic                       w_haveInv;
  logic [WAY_W-1:0]           w_victim;
  logic                       w_victimDirty;
  mesi_t                      w_fillMesi;
  logic [ADDR_W-1:0]          w_fillAddr;
  logic [ADDR_W-1:0]          w_victimAddr;
  logic [WAYS-1:0][WAY_W-1:0] w_lruAges;
  logic                       w_unusedOffset;

  assign w_unusedOffset = ^req_addr[OFFSET_W-1:0];
  assign w_set          = r_line[IDX_W-1:0];
  assign w_reqTag       = r_line[LINE_W-1:IDX_W];
  assign w_hitMesi      = r_mesi[w_set][w_hitWay];
  assign w_victimDirty  = (r_mesi[w_set][w_victim] == MESI_M);
  assign w_fillMesi     = (r_cmd == CMD_WRITE) ? MESI_M : (mem_shared ? MESI_S : MESI_E);
  assign w_fillAddr     = {r_line, {OFFSET_W{1'b0}}};
  assign w_victimAddr   = {r_tag[w_set][w_victim], w_set, {OFFSET_W{1'b0}}};

  // Tag match across the set, then victim: first invalid way, else the oldest.
  always_comb begin
    w_hit     = 1'b0;
    w_hitWay  = '0;
    w_haveInv = 1'b0;
    w_victim  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && r_mesi[w_set][w] != MESI_I && r_tag[w_set][w] == w_reqTag) begin
        w_hit    = 1'b1;
        w_hitWay = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!w_haveInv && r_mesi[w_set][w] == MESI_I) begin
        w_haveInv = 1'b1;
        w_victim  = WAY_W'(w);
      end
    end
    if (!w_haveInv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[w_set][w] == WAY_W'(WAYS - 1))
          w_victim = WAY_W'(w);
      end
    end
  end

  lru_age_update #(.WAYS(WAYS)) u_lru (
    .i_ages (r_age[w_set]),
    .i_way  (r_way),
    .o_ages (w_lruAges)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cmd         <= '0;
      r_line        <= '0;
      r_way         <= '0;
      r_hit         <= 1'b0;
      r_newMesi     <= MESI_I;
      r_clrSet      <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_way      <= '0;
      resp_mesi     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_wb    <= 1'b0;
      mem_req_addr  <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_tag[s][w]  <= '0;
          r_mesi[s][w] <= MESI_I;
          r_age[s][w]  <= WAY_W'(w);
        end
      end
`ifdef CACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_cmd     <= req_cmd;
            r_line    <= req_addr[ADDR_W-1:OFFSET_W];
            req_ready <= 1'b0;
            if (req_cmd == CMD_CLEAR) begin
              r_clrSet <= '0;
              r_state  <= ST_CLEAR;
`ifdef CACHE_STATS_EN
              hit_count  <= '0;
              miss_count <= '0;
`endif
            end else begin
              r_state <= ST_LOOKUP;
            end
          end
        end

        ST_LOOKUP: begin
          r_hit <= w_hit;
          if (isAccessCmd(r_cmd) && !w_hit) begin
            r_way         <= w_victim;
            mem_req_valid <= 1'b1;
            mem_req_wb    <= w_victimDirty;
            mem_req_addr  <= w_victimDirty ? w_victimAddr : w_fillAddr;
            r_state       <= w_victimDirty ? ST_WB : ST_FILL;
          end else begin
            r_way      <= w_hitWay;
            r_newMesi  <= (r_cmd == CMD_WRITE) ? MESI_M : w_hitMesi;
            resp_valid <= 1'b1;
            r_state    <= ST_UPDATE;
            if (isAccessCmd(r_cmd)) begin
              resp_hit  <= 1'b1;
              resp_way  <= w_hitWay;
              resp_mesi <= (r_cmd == CMD_WRITE) ? MESI_M : w_hitMesi;
            end else if (r_cmd == CMD_INVAL && w_hit) begin
              resp_hit  <= 1'b1;
              resp_way  <= w_hitWay;
              resp_mesi <= MESI_I;
            end else begin
              resp_hit  <= 1'b0;
              resp_way  <= '0;
              resp_mesi <= MESI_I;
            end
          end
        end

        ST_WB: begin
          if (mem_ack) begin
            mem_req_wb   <= 1'b0;
            mem_req_addr <= w_fillAddr;
            r_state      <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (mem_ack) begin
            mem_req_valid        <= 1'b0;
            r_tag[w_set][r_way]  <= w_reqTag;
            r_newMesi            <= w_fillMesi;
            resp_hit             <= 1'b0;
            resp_way             <= r_way;
            resp_mesi            <= w_fillMesi;
            resp_valid           <= 1'b1;
            r_state              <= ST_UPDATE;
          end
        end

        ST_UPDATE: begin
          if (isAccessCmd(r_cmd)) begin
            r_mesi[w_set][r_way] <= r_newMesi;
            r_age[w_set]         <= w_lruAges;
`ifdef CACHE_STATS_EN
            if (r_hit) begin
              if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
              if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
`endif
          end else if (r_cmd == CMD_INVAL && r_hit) begin
            r_mesi[w_set][r_way] <= MESI_I;
          end
          req_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end

        ST_CLEAR: begin
          for (int w = 0; w < WAYS; w++) begin
            r_mesi[r_clrSet][w] <= MESI_I;
            r_age[r_clrSet][w]  <= WAY_W'(w);
          end
          // The response cycle after the last set reuses UPDATE, which commits nothing for this command.
          if (r_clrSet == IDX_W'(SETS - 1)) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_way   <= '0;
            resp_mesi  <= MESI_I;
            r_state    <= ST_UPDATE;
          end else begin
            r_clrSet <= r_clrSet + 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Directed bench for cache_set_ctrl as a 4-way, 16-set instance: hit/miss, LRU
// victim order, writeback, invalidate, clear-all and reset during writeback.
module tb_cache_set_ctrl;
  import cache_set_ctrl_pkg::*;

  localparam int WAYS     = 4;
  localparam int SETS     = 16;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_cmd = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic        resp_valid;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic [1:0]  resp_mesi;
  logic        mem_req_valid;
  logic        mem_req_wb;
  logic [31:0] mem_req_addr;
  logic        mem_ack = 1'b0;
  logic        mem_shared = 1'b0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int testCount = 0;
  int failCount = 0;

  logic        rHit;
  logic [1:0]  rWay;
  logic [1:0]  rMesi;
  int          rLat;
  int          readyLow;
  bit          sawWb, sawFill, wbFirst, timedOut;
  logic [31:0] wbAddr, fillAddr;

  always #5 clk = ~clk;

  cache_set_ctrl #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cmd       (req_cmd),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .resp_way      (resp_way),
    .resp_mesi     (resp_mesi),
    .mem_req_valid (mem_req_valid),
    .mem_req_wb    (mem_req_wb),
    .mem_req_addr  (mem_req_addr),
    .mem_ack       (mem_ack),
    .mem_shared    (mem_shared)
`ifdef CACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One command end to end; memory requests are acked in the cycle they appear.
  task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] addr, input logic shared);
    int cyc;
    sawWb = 0; sawFill = 0; wbFirst = 0; timedOut = 1; readyLow = 0; rLat = 0;
    wbAddr = '0; fillAddr = '0;
    for (int i = 0; i < 50 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b1; req_cmd = cmd; req_addr = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    for (int i = 0; i < 100; i++) begin
      mem_ack = 1'b0;
      if (!req_ready) readyLow++;
      if (resp_valid) begin
        rHit = resp_hit; rWay = resp_way; rMesi = resp_mesi; rLat = cyc; timedOut = 0;
        break;
      end
      if (mem_req_valid) begin
        if (mem_req_wb) begin
          sawWb = 1; wbAddr = mem_req_addr;
        end else begin
          if (!sawFill) wbFirst = sawWb;
          sawFill = 1; fillAddr = mem_req_addr;
        end
        mem_ack = 1'b1; mem_shared = shared;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_ack = 1'b0;
    checkOutput("resp_timeout", {31'd0, timedOut}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    checkOutput("rst_mem_wb", {31'd0, mem_req_wb}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(CMD_READ, 32'h0000_1040, 1'b0);
    checkOutput("miss1_hit", {31'd0, rHit}, 32'd0);
    checkOutput("miss1_way", {30'd0, rWay}, 32'd0);
    checkOutput("miss1_mesi", {30'd0, rMesi}, 32'(MESI_E));
    checkOutput("miss1_fill", {31'd0, sawFill}, 32'd1);
    checkOutput("miss1_fill_addr", fillAddr, 32'h0000_1040);
    checkOutput("miss1_no_wb", {31'd0, sawWb}, 32'd0);

    applyStimulus(CMD_READ, 32'h0000_1040, 1'b0);
    checkOutput("hit_hit", {31'd0, rHit}, 32'd1);
    checkOutput("hit_way", {30'd0, rWay}, 32'd0);
    checkOutput("hit_mesi", {30'd0, rMesi}, 32'(MESI_E));
    checkOutput("hit_latency", rLat, 32'd2);
    checkOutput("hit_no_mem", {31'd0, sawFill | sawWb}, 32'd0);

    applyStimulus(CMD_WRITE, 32'h0000_1040, 1'b0);
    checkOutput("whit_hit", {31'd0, rHit}, 32'd1);
    checkOutput("whit_mesi", {30'd0, rMesi}, 32'(MESI_M));

    applyStimulus(CMD_READ, 32'h0000_1440, 1'b1);
    checkOutput("fill_s_way", {30'd0, rWay}, 32'd1);
    checkOutput("fill_s_mesi", {30'd0, rMesi}, 32'(MESI_S));
    applyStimulus(CMD_FETCH, 32'h0000_1840, 1'b0);
    checkOutput("fetch_way", {30'd0, rWay}, 32'd2);
    applyStimulus(CMD_WRITE, 32'h0000_1C40, 1'b0);
    checkOutput("wfill_way", {30'd0, rWay}, 32'd3);
    checkOutput("wfill_mesi", {30'd0, rMesi}, 32'(MESI_M));

    applyStimulus(CMD_READ, 32'h0000_2040, 1'b0);
    checkOutput("evict_wb", {31'd0, sawWb}, 32'd1);
    checkOutput("evict_wb_addr", wbAddr, 32'h0000_1040);
    checkOutput("evict_wb_first", {31'd0, wbFirst}, 32'd1);
    checkOutput("evict_fill_addr", fillAddr, 32'h0000_2040);
    checkOutput("evict_way", {30'd0, rWay}, 32'd0);
    checkOutput("evict_mesi", {30'd0, rMesi}, 32'(MESI_E));

    applyStimulus(CMD_READ, 32'h0000_0480, 1'b0);
    applyStimulus(CMD_READ, 32'h0000_0880, 1'b0);
    applyStimulus(CMD_READ, 32'h0000_0C80, 1'b0);
    applyStimulus(CMD_READ, 32'h0000_1080, 1'b0);
    checkOutput("lru_fill_way3", {30'd0, rWay}, 32'd3);
    applyStimulus(CMD_READ, 32'h0000_0C80, 1'b0);
    checkOutput("lru_touch_hit", {31'd0, rHit}, 32'd1);
    checkOutput("lru_touch_way", {30'd0, rWay}, 32'd2);
    applyStimulus(CMD_READ, 32'h0000_1480, 1'b0);
    checkOutput("lru_victim_way", {30'd0, rWay}, 32'd0);
    checkOutput("lru_victim_no_wb", {31'd0, sawWb}, 32'd0);

    applyStimulus(CMD_INVAL, 32'h0000_0880, 1'b0);
    checkOutput("inval_hit", {31'd0, rHit}, 32'd1);
    checkOutput("inval_way", {30'd0, rWay}, 32'd1);
    checkOutput("inval_mesi", {30'd0, rMesi}, 32'(MESI_I));
    applyStimulus(CMD_READ, 32'h0000_0880, 1'b0);
    checkOutput("reread_hit", {31'd0, rHit}, 32'd0);
    checkOutput("reread_way", {30'd0, rWay}, 32'd1);
    checkOutput("reread_fill", {31'd0, sawFill}, 32'd1);
    applyStimulus(CMD_INVAL, 32'h0000_3C80, 1'b0);
    checkOutput("inval_miss_hit", {31'd0, rHit}, 32'd0);
    checkOutput("inval_miss_no_mem", {31'd0, sawFill | sawWb}, 32'd0);

    applyStimulus(CMD_NOP, 32'h0000_1040, 1'b0);
    checkOutput("nop_latency", rLat, 32'd2);
    checkOutput("nop_hit", {31'd0, rHit}, 32'd0);
    applyStimulus(4'd5, 32'h0000_1040, 1'b0);
    checkOutput("undef_cmd_hit", {31'd0, rHit}, 32'd0);

    applyStimulus(CMD_CLEAR, 32'h0000_0000, 1'b0);
    checkOutput("clear_latency", rLat, 32'(SETS + 1));
    checkOutput("clear_ready_low", readyLow, 32'(SETS + 1));
    checkOutput("clear_ready_after", {31'd0, req_ready}, 32'd1);
`ifdef CACHE_STATS_EN
    checkOutput("clear_hit_count", hit_count, 32'd0);
    checkOutput("clear_miss_count", miss_count, 32'd0);
`endif
    applyStimulus(CMD_READ, 32'h0000_2040, 1'b0);
    checkOutput("post_clear_hit", {31'd0, rHit}, 32'd0);
    checkOutput("post_clear_way", {30'd0, rWay}, 32'd0);
`ifdef CACHE_STATS_EN
    checkOutput("post_clear_miss_count", miss_count, 32'd1);
`endif

    applyStimulus(CMD_WRITE, 32'h0000_04C0, 1'b0);
    applyStimulus(CMD_WRITE, 32'h0000_08C0, 1'b0);
    applyStimulus(CMD_WRITE, 32'h0000_0CC0, 1'b0);
    applyStimulus(CMD_WRITE, 32'h0000_10C0, 1'b0);
    req_valid = 1'b1; req_cmd = CMD_READ; req_addr = 32'h0000_14C0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid && mem_req_wb) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("rstwb_wb_seen", {31'd0, found}, 32'd1);
    checkOutput("rstwb_wb_addr", mem_req_addr, 32'h0000_04C0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstwb_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    checkOutput("rstwb_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rstwb_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput("rstwb_no_late_resp", {31'd0, resp_valid}, 32'd0);
    applyStimulus(CMD_READ, 32'h0000_10C0, 1'b0);
    checkOutput("rstwb_reread_hit", {31'd0, rHit}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
